// File: rtl/agu_vec_if.sv
// agu_vec_if: request/result bundle between a vector address requester and agu_vec.
interface agu_vec_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [1:0]                  mode_i;
  logic [1:0]                  size_i;
  logic [1:0]                  shift_i;
  logic [NUM_LANES-1:0]        mask_i;
  logic [NUM_LANES*DATA_W-1:0] base_i;
  logic [NUM_LANES*DATA_W-1:0] idx_i;
  logic [IMM_W-1:0]            immd_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [NUM_LANES*DATA_W-1:0] addr_o;
  logic [NUM_LANES-1:0]        mask_o;
  logic [NUM_LANES-1:0]        misalign_o;
  logic                        coalesced_o;
  logic                        mode_err_o;
  modport master (
    output in_valid_i, mode_i, size_i, shift_i, mask_i, base_i, idx_i, immd_i, out_ready_i,
    input  in_ready_o, out_valid_o, addr_o, mask_o, misalign_o, coalesced_o, mode_err_o
  );
  modport slave (
    input  in_valid_i, mode_i, size_i, shift_i, mask_i, base_i, idx_i, immd_i, out_ready_i,
    output in_ready_o, out_valid_o, addr_o, mask_o, misalign_o, coalesced_o, mode_err_o
  );
endinterface

// File: rtl/agu_vec.sv
// agu_vec: two-stage vector address generator with misalignment and line-coalescing flags.
module agu_vec #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int LINE_LOG2 = 7
) (
  input logic       clk_i,
  input logic       reset_i,
  agu_vec_if.slave  bus
);
  localparam int L = NUM_LANES;
  localparam int W = DATA_W;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [L*W-1:0] s1_base, s1_sidx, sidx, sum;
  logic [W-1:0] s1_imm, imm_sx;
  logic [L-1:0] s1_mask, mis;
  logic [1:0] s1_size;
  logic s1_err, use_idx, use_imm, coal;
  logic [2:0] lowm;
  logic [W-LINE_LOG2-1:0] ref_line;
  assign s2_adv = !s2_valid | bus.out_ready_i;
  assign s1_adv = !s1_valid | s2_adv;
  assign bus.in_ready_o = s1_adv;
  assign bus.out_valid_o = s2_valid;
  // Mode selects which terms reach the adder; unused terms are zeroed in S1.
  always_comb begin
    use_idx = ^bus.mode_i;
    use_imm = bus.mode_i != 2'b01;
    imm_sx = use_imm ? W'($signed(bus.immd_i)) : '0;
    sidx = '0;
    for (int i = 0; i < L; i++)
      sidx[i*W +: W] = use_idx ? (bus.idx_i[i*W +: W] << bus.shift_i) : '0;
  end
  always_comb begin
    lowm = {s1_size == 2'd3, s1_size[1], |s1_size};
    sum = '0;
    mis = '0;
    ref_line = '0;
    for (int i = 0; i < L; i++) begin
      sum[i*W +: W] = s1_mask[i] ? s1_base[i*W +: W] + s1_sidx[i*W +: W] + s1_imm : '0;
      mis[i] = s1_mask[i] & |(sum[i*W +: 3] & lowm);
      if (s1_mask[i]) ref_line = sum[i*W+LINE_LOG2 +: W-LINE_LOG2];
    end
    coal = |s1_mask;
    for (int i = 0; i < L; i++)
      if (s1_mask[i] && sum[i*W+LINE_LOG2 +: W-LINE_LOG2] != ref_line) coal = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      bus.addr_o <= '0;
      bus.mask_o <= '0;
      bus.misalign_o <= '0;
      bus.coalesced_o <= 1'b0;
      bus.mode_err_o <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid_i;
        s1_base <= bus.base_i;
        s1_sidx <= sidx;
        s1_imm <= imm_sx;
        s1_mask <= bus.mask_i;
        s1_size <= bus.size_i;
        s1_err <= &bus.mode_i;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        bus.addr_o <= sum;
        bus.mask_o <= s1_mask;
        bus.misalign_o <= mis;
        bus.coalesced_o <= coal;
        bus.mode_err_o <= s1_err;
      end
    end
  end
endmodule

// File: tb/tb_agu_vec.sv
// tb_agu_vec: directed-vector bench for agu_vec, one task per scenario.
module tb_agu_vec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  agu_vec_if #(.NUM_LANES(4), .DATA_W(32), .IMM_W(16)) bus ();
  agu_vec #(.NUM_LANES(4), .DATA_W(32), .IMM_W(16), .LINE_LOG2(7)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] mode, input logic [1:0] size, input logic [1:0] shift,
                       input logic [3:0] mask, input logic [127:0] base, input logic [127:0] idx,
                       input logic [15:0] imm);
    bus.in_valid_i = 1'b1;
    bus.mode_i = mode;
    bus.size_i = size;
    bus.shift_i = shift;
    bus.mask_i = mask;
    bus.base_i = base;
    bus.idx_i = idx;
    bus.immd_i = imm;
  endtask

  task automatic finish_send();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(2'b00, 2'd0, 2'd0, 4'b0, '0, '0, 16'h0);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", bus.out_valid_o); end
    if (bus.addr_o !== 128'h0) begin failures++; $display("FAIL reset_addr got %h exp 0", bus.addr_o); end
    if (bus.mask_o !== 4'h0) begin failures++; $display("FAIL reset_mask got %b exp 0", bus.mask_o); end
    if (bus.misalign_o !== 4'h0) begin failures++; $display("FAIL reset_misalign got %b exp 0", bus.misalign_o); end
    if (bus.coalesced_o !== 1'b0) begin failures++; $display("FAIL reset_coal got %b exp 0", bus.coalesced_o); end
    if (bus.mode_err_o !== 1'b0) begin failures++; $display("FAIL reset_moderr got %b exp 0", bus.mode_err_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", bus.in_ready_o); end
  endtask

  task automatic test_base_imm();
    @(negedge clk);
    drive(2'b00, 2'd2, 2'd0, 4'b0001, {32'h9, 32'h9, 32'h9, 32'h0000_1000}, '0, 16'hFFFC);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bi_latency1 got %b exp 0", bus.out_valid_o); end
    @(negedge clk);
    checks += 6;
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bi_valid got %b exp 1", bus.out_valid_o); end
    if (bus.addr_o !== {96'h0, 32'h0000_0FFC}) begin failures++; $display("FAIL bi_addr got %h exp %h", bus.addr_o, {96'h0, 32'h0000_0FFC}); end
    if (bus.misalign_o !== 4'b0000) begin failures++; $display("FAIL bi_misalign got %b exp 0000", bus.misalign_o); end
    if (bus.coalesced_o !== 1'b1) begin failures++; $display("FAIL bi_coal got %b exp 1", bus.coalesced_o); end
    if (bus.mask_o !== 4'b0001) begin failures++; $display("FAIL bi_mask got %b exp 0001", bus.mask_o); end
    if (bus.mode_err_o !== 1'b0) begin failures++; $display("FAIL bi_moderr got %b exp 0", bus.mode_err_o); end
  endtask

  task automatic test_idx_imm();
    @(negedge clk);
    drive(2'b10, 2'd2, 2'd2, 4'b1111, {4{32'h100}}, {32'd3, 32'd2, 32'd1, 32'd0}, 16'h0004);
    finish_send();
    checks += 3;
    if (bus.addr_o !== {32'h110, 32'h10C, 32'h108, 32'h104}) begin failures++; $display("FAIL ii_addr got %h exp %h", bus.addr_o, {32'h110, 32'h10C, 32'h108, 32'h104}); end
    if (bus.coalesced_o !== 1'b1) begin failures++; $display("FAIL ii_coal got %b exp 1", bus.coalesced_o); end
    if (bus.misalign_o !== 4'b0000) begin failures++; $display("FAIL ii_misalign got %b exp 0000", bus.misalign_o); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive(2'b00, 2'd3, 2'd0, 4'b1111, {32'h0, 32'h60, 32'hFFFF_FFEC, 32'hFFFF_FFF0}, '0, 16'h0020);
    finish_send();
    checks += 3;
    if (bus.addr_o !== {32'h20, 32'h80, 32'h0C, 32'h10}) begin failures++; $display("FAIL wr_addr got %h exp %h", bus.addr_o, {32'h20, 32'h80, 32'h0C, 32'h10}); end
    if (bus.misalign_o !== 4'b0010) begin failures++; $display("FAIL wr_misalign got %b exp 0010", bus.misalign_o); end
    if (bus.coalesced_o !== 1'b0) begin failures++; $display("FAIL wr_coal got %b exp 0", bus.coalesced_o); end
    @(negedge clk);
    drive(2'b01, 2'd0, 2'd3, 4'b0011, {32'h0, 32'h0, 32'h0, 32'h3}, {32'h0, 32'h0, 32'h2000_0001, 32'h5}, 16'h7777);
    finish_send();
    checks += 3;
    if (bus.addr_o !== {32'h0, 32'h0, 32'h8, 32'h2B}) begin failures++; $display("FAIL idx_addr got %h exp %h", bus.addr_o, {32'h0, 32'h0, 32'h8, 32'h2B}); end
    if (bus.misalign_o !== 4'b0000) begin failures++; $display("FAIL idx_size0 got %b exp 0000", bus.misalign_o); end
    if (bus.coalesced_o !== 1'b1) begin failures++; $display("FAIL idx_coal got %b exp 1", bus.coalesced_o); end
  endtask

  task automatic test_zero_mask();
    @(negedge clk);
    drive(2'b00, 2'd2, 2'd0, 4'b0000, {4{32'h1234}}, '0, 16'h0004);
    finish_send();
    checks += 4;
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL zm_valid got %b exp 1", bus.out_valid_o); end
    if (bus.addr_o !== 128'h0) begin failures++; $display("FAIL zm_addr got %h exp 0", bus.addr_o); end
    if (bus.coalesced_o !== 1'b0) begin failures++; $display("FAIL zm_coal got %b exp 0", bus.coalesced_o); end
    if (bus.mask_o !== 4'b0000) begin failures++; $display("FAIL zm_mask got %b exp 0000", bus.mask_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bus.out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc >= 2 && cyc < 5) begin
        e = 32'h40 * (cyc - 1);
        checks += 2;
        if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got %b exp 1", cyc, bus.out_valid_o); end
        if (bus.addr_o !== {96'h0, e}) begin failures++; $display("FAIL b2b_addr%0d got %h exp %h", cyc, bus.addr_o, {96'h0, e}); end
      end
      if (cyc == 5) begin
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid_o); end
      end
      if (cyc < 3) drive(2'b00, 2'd0, 2'd0, 4'b0001, {96'h0, 32'(32'h40 * (cyc + 1))}, '0, 16'h0);
      else bus.in_valid_i = 1'b0;
      #1;
      checks++;
      if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got %b exp 1", cyc, bus.in_ready_o); end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic [31:0] e;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready_i = (cyc >= 7);
      if (sent < 4) drive(2'b00, 2'd0, 2'd0, 4'b0001, {96'h0, 32'(32'h100 * (sent + 1))}, '0, 16'h0);
      else bus.in_valid_i = 1'b0;
      #1;
      if (cyc >= 2 && cyc < 7) begin
        checks += 3;
        if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got %b exp 0", cyc, bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got %b exp 1", cyc, bus.out_valid_o); end
        if (bus.addr_o !== {96'h0, 32'h100}) begin failures++; $display("FAIL bp_hold%0d got %h exp %h", cyc, bus.addr_o, {96'h0, 32'h100}); end
      end
      if (cyc == 7) begin
        checks++;
        if (sent !== 2) begin failures++; $display("FAIL bp_accepted got %0d exp 2", sent); end
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        e = 32'h100 * (got + 1);
        checks++;
        if (bus.addr_o !== {96'h0, e}) begin failures++; $display("FAIL bp_order%0d got %h exp %h", got, bus.addr_o, {96'h0, e}); end
        got++;
      end
      if (bus.in_valid_i && bus.in_ready_o) sent++;
    end
    checks++;
    if (got !== 4 || sent !== 4) begin failures++; $display("FAIL bp_timeout got %0d/%0d exp 4/4", got, sent); end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    drive(2'b00, 2'd0, 2'd0, 4'b0001, {96'h0, 32'h500}, '0, 16'h0);
    @(negedge clk);
    drive(2'b00, 2'd0, 2'd0, 4'b0001, {96'h0, 32'h600}, '0, 16'h0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL mr_valid got %b exp 0", bus.out_valid_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL mr_ready got %b exp 1", bus.in_ready_o); end
    if (bus.addr_o !== 128'h0) begin failures++; $display("FAIL mr_addr got %h exp 0", bus.addr_o); end
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL mr_stale%0d got %b exp 0", cyc, bus.out_valid_o); end
    end
  endtask

  task automatic test_mode_err();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    drive(2'b11, 2'd0, 2'd1, 4'b0001, {96'h0, 32'h2000}, {96'h0, 32'h5}, 16'h0010);
    @(negedge clk);
    drive(2'b10, 2'd0, 2'd1, 4'b0001, {96'h0, 32'h2000}, {96'h0, 32'h5}, 16'hFFFF);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    checks += 2;
    if (bus.addr_o !== {96'h0, 32'h2010}) begin failures++; $display("FAIL me_addr got %h exp %h", bus.addr_o, {96'h0, 32'h2010}); end
    if (bus.mode_err_o !== 1'b1) begin failures++; $display("FAIL me_flag got %b exp 1", bus.mode_err_o); end
    @(negedge clk);
    checks += 2;
    if (bus.addr_o !== {96'h0, 32'h2009}) begin failures++; $display("FAIL me_next_addr got %h exp %h", bus.addr_o, {96'h0, 32'h2009}); end
    if (bus.mode_err_o !== 1'b0) begin failures++; $display("FAIL me_next_flag got %b exp 0", bus.mode_err_o); end
  endtask

  initial begin
    test_reset();
    test_base_imm();
    test_idx_imm();
    test_wrap();
    test_zero_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_mode_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
